// File: rtl/fsm_seq_ctrl.sv
// Table-driven sequencer: a writable 16-entry {state,a} -> {next,out} table
// stepped by a small IDLE/RUN controller with stop, halt-state and step-limit exits.
module fsm_seq_ctrl #(
  parameter int MAXW = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_we,
  input  logic [3:0]      cfg_addr,
  input  logic [5:0]      cfg_data,
  output logic [5:0]      cfg_rdata,
  output logic            cfg_err,
  input  logic            start,
  input  logic [2:0]      start_st,
  input  logic            stop,
  input  logic            halt_en,
  input  logic [2:0]      halt_st,
  input  logic [MAXW-1:0] max_steps,
  input  logic            a,
  output logic [2:0]      s,
  output logic [2:0]      state,
  output logic            busy,
  output logic [MAXW-1:0] steps,
  output logic            done,
  output logic [1:0]      done_code
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } ctrl_e;

  localparam logic [1:0] CODE_NONE  = 2'b00;
  localparam logic [1:0] CODE_HALT  = 2'b01;
  localparam logic [1:0] CODE_LIMIT = 2'b10;
  localparam logic [1:0] CODE_STOP  = 2'b11;

  // Built-in program: the 0/3/2/4/5 counting cycle, packed as {next, out}.
  function automatic logic [5:0] default_entry(input logic [3:0] idx);
    logic [5:0] e;
    case (idx)
      4'd0, 4'd1: e = {3'd1, 3'd0};
      4'd2:       e = {3'd2, 3'd3};
      4'd3:       e = {3'd4, 3'd3};
      4'd4, 4'd5: e = {3'd3, 3'd2};
      4'd6:       e = {3'd0, 3'd4};
      4'd7:       e = {3'd1, 3'd4};
      4'd8, 4'd9: e = {3'd2, 3'd5};
      default:    e = {3'd0, 3'd0};
    endcase
    return e;
  endfunction

  ctrl_e           ctrl_q, ctrl_d;
  logic [5:0]      table_q [16];
  logic [5:0]      table_d [16];
  logic [2:0]      state_q, state_d;
  logic [MAXW-1:0] steps_q, steps_d;
  logic            done_q, done_d;
  logic [1:0]      done_code_q, done_code_d;
  logic            cfg_err_q, cfg_err_d;

  logic [5:0]      entry_s;
  logic [2:0]      next_s;
  logic            limit_hit_s;

  assign entry_s     = table_q[{state_q, a}];
  assign next_s      = entry_s[5:3];
  // Compare one bit wider so a saturated counter can never alias the limit.
  assign limit_hit_s = (max_steps != {MAXW{1'b0}}) &&
                       (({1'b0, steps_q} + {{MAXW{1'b0}}, 1'b1}) == {1'b0, max_steps});

  // Controller next-state, table update and termination decode.
  always_comb begin
    ctrl_d      = ctrl_q;
    table_d     = table_q;
    state_d     = state_q;
    steps_d     = steps_q;
    done_d      = 1'b0;
    done_code_d = done_code_q;
    cfg_err_d   = 1'b0;
    case (ctrl_q)
      IDLE: begin
        if (cfg_we) begin
          table_d[cfg_addr] = cfg_data;
        end else begin
          table_d = table_q;
        end
        if (start) begin
          state_d     = start_st;
          steps_d     = {MAXW{1'b0}};
          done_code_d = CODE_NONE;
          ctrl_d      = RUN;
        end else begin
          ctrl_d = IDLE;
        end
      end
      RUN: begin
        cfg_err_d = cfg_we;
        if (stop) begin
          ctrl_d      = IDLE;
          done_d      = 1'b1;
          done_code_d = CODE_STOP;
        end else begin
          state_d = next_s;
          if (steps_q == {MAXW{1'b1}}) begin
            steps_d = steps_q;
          end else begin
            steps_d = steps_q + {{(MAXW-1){1'b0}}, 1'b1};
          end
          if (halt_en && (next_s == halt_st)) begin
            ctrl_d      = IDLE;
            done_d      = 1'b1;
            done_code_d = CODE_HALT;
          end else if (limit_hit_s) begin
            ctrl_d      = IDLE;
            done_d      = 1'b1;
            done_code_d = CODE_LIMIT;
          end else begin
            ctrl_d = RUN;
          end
        end
      end
      default: begin
        ctrl_d = IDLE;
      end
    endcase
  end

  // State, table and status registers; reset restores the default program.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q      <= IDLE;
      state_q     <= 3'd0;
      steps_q     <= {MAXW{1'b0}};
      done_q      <= 1'b0;
      done_code_q <= CODE_NONE;
      cfg_err_q   <= 1'b0;
      for (int i = 0; i < 16; i++) begin
        table_q[i] <= default_entry(4'(i));
      end
    end else begin
      ctrl_q      <= ctrl_d;
      state_q     <= state_d;
      steps_q     <= steps_d;
      done_q      <= done_d;
      done_code_q <= done_code_d;
      cfg_err_q   <= cfg_err_d;
      for (int i = 0; i < 16; i++) begin
        table_q[i] <= table_d[i];
      end
    end
  end

  assign busy      = (ctrl_q == RUN);
  assign s         = busy ? entry_s[2:0] : 3'd0;
  assign cfg_rdata = table_q[cfg_addr];
  assign state     = state_q;
  assign steps     = steps_q;
  assign done      = done_q;
  assign done_code = done_code_q;
  assign cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Self-checking bench for fsm_seq_ctrl: a per-cycle behavioural model compared on
// every falling edge, plus directed scenarios with hand-computed expectations.
module tb_fsm_seq_ctrl;
  localparam int MAXW = 8;

  logic            clk = 1'b0;
  logic            reset;
  logic            cfg_we;
  logic [3:0]      cfg_addr;
  logic [5:0]      cfg_data;
  logic [5:0]      cfg_rdata;
  logic            cfg_err;
  logic            start;
  logic [2:0]      start_st;
  logic            stop;
  logic            halt_en;
  logic [2:0]      halt_st;
  logic [MAXW-1:0] max_steps;
  logic            a;
  logic [2:0]      s;
  logic [2:0]      state;
  logic            busy;
  logic [MAXW-1:0] steps;
  logic            done;
  logic [1:0]      done_code;

  fsm_seq_ctrl #(.MAXW(MAXW)) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .cfg_rdata(cfg_rdata), .cfg_err(cfg_err),
    .start(start), .start_st(start_st), .stop(stop), .halt_en(halt_en),
    .halt_st(halt_st), .max_steps(max_steps), .a(a), .s(s), .state(state),
    .busy(busy), .steps(steps), .done(done), .done_code(done_code)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: separate next/out lists straight from the default program.
  int m_next [16];
  int m_out  [16];
  int m_state, m_steps, m_count, m_code;
  bit m_busy, m_done, m_err;

  task automatic model_reset();
    int nx[16] = '{1, 1, 2, 4, 3, 3, 0, 1, 2, 2, 0, 0, 0, 0, 0, 0};
    int ot[16] = '{0, 0, 3, 3, 2, 2, 4, 4, 5, 5, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 16; i++) begin
      m_next[i] = nx[i];
      m_out[i]  = ot[i];
    end
    m_state = 0; m_steps = 0; m_count = 0; m_code = 0;
    m_busy = 0; m_done = 0; m_err = 0;
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_reset();
    end else begin
      m_done = 0;
      m_err  = 0;
      if (!m_busy) begin
        if (cfg_we) begin
          m_next[cfg_addr] = int'(cfg_data) / 8;
          m_out[cfg_addr]  = int'(cfg_data) % 8;
        end
        if (start) begin
          m_state = start_st; m_steps = 0; m_count = 0; m_code = 0; m_busy = 1;
        end
      end else begin
        m_err = cfg_we;
        if (stop) begin
          m_busy = 0; m_done = 1; m_code = 3;
        end else begin
          m_state = m_next[m_state * 2 + int'(a)];
          m_count = m_count + 1;
          if (m_steps < 255) m_steps = m_steps + 1;
          if (halt_en && m_state == int'(halt_st)) begin
            m_busy = 0; m_done = 1; m_code = 1;
          end else if (max_steps != 0 && m_count == int'(max_steps)) begin
            m_busy = 0; m_done = 1; m_code = 2;
          end
        end
      end
    end
  end

  // Compare process: every output against the model on each falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("s", int'(s), m_busy ? m_out[m_state * 2 + int'(a)] : 0);
      check("state", int'(state), m_state);
      check("busy", int'(busy), int'(m_busy));
      check("steps", int'(steps), m_steps);
      check("done", int'(done), int'(m_done));
      check("done_code", int'(done_code), m_code);
      check("cfg_err", int'(cfg_err), int'(m_err));
      check("cfg_rdata", int'(cfg_rdata), m_next[cfg_addr] * 8 + m_out[cfg_addr]);
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic run_from(input logic [2:0] st);
    start_st = st;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  int exp_s0[8]  = '{0, 3, 2, 4, 0, 3, 2, 4};
  int exp_q0[8]  = '{0, 1, 2, 3, 0, 1, 2, 3};
  int exp_s1[9]  = '{0, 3, 5, 2, 4, 3, 5, 2, 4};
  int exp_q1[9]  = '{0, 1, 4, 2, 3, 1, 4, 2, 3};

  initial begin
    reset = 1'b0; cfg_we = 1'b0; cfg_addr = 4'd2; cfg_data = 6'd0;
    start = 1'b0; start_st = 3'd0; stop = 1'b0; halt_en = 1'b0;
    halt_st = 3'd0; max_steps = 8'd0; a = 1'b0;
    repeat (2) @(negedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    cyc();
    check("rst_busy", int'(busy), 0);
    check("rst_state", int'(state), 0);
    check("rst_code", int'(done_code), 0);
    check("rst_rdata2", int'(cfg_rdata), 19);

    // Default program, a=0, free running.
    run_from(3'd0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      check("seq_a0_s", int'(s), exp_s0[i]);
      check("seq_a0_state", int'(state), exp_q0[i]);
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    check("stop_done", int'(done), 1);
    check("stop_code", int'(done_code), 3);
    check("stop_state", int'(state), 3);

    // Default program, a=1; start in RUN must be ignored.
    a = 1'b1;
    run_from(3'd0);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) cyc();
      check("seq_a1_s", int'(s), exp_s1[i]);
      check("seq_a1_state", int'(state), exp_q1[i]);
      start = (i == 2); start_st = 3'd6;
    end
    start = 1'b0;
    stop = 1'b1; cyc(); stop = 1'b0;
    a = 1'b0;

    // Step limit, then halt beating limit on the same edge.
    max_steps = 8'd4;
    run_from(3'd0);
    repeat (4) cyc();
    check("lim_done", int'(done), 1);
    check("lim_steps", int'(steps), 4);
    check("lim_state", int'(state), 0);
    check("lim_code", int'(done_code), 2);
    check("lim_busy", int'(busy), 0);
    cyc();
    check("lim_done_pulse", int'(done), 0);
    check("lim_code_held", int'(done_code), 2);
    halt_en = 1'b1; halt_st = 3'd0;
    run_from(3'd0);
    check("restart_code", int'(done_code), 0);
    repeat (4) cyc();
    check("halt_wins_code", int'(done_code), 1);
    max_steps = 8'd0;

    // Halt at state 3, then stop on the second edge of a run.
    halt_st = 3'd3;
    run_from(3'd0);
    repeat (3) cyc();
    check("halt_state", int'(state), 3);
    check("halt_code", int'(done_code), 1);
    check("halt_steps", int'(steps), 3);
    run_from(3'd0);
    cyc();
    stop = 1'b1; cyc(); stop = 1'b0;
    check("stop2_state", int'(state), 1);
    check("stop2_code", int'(done_code), 3);
    halt_en = 1'b0;

    // Table write in IDLE, then a run through the rewritten entry.
    cfg_addr = 4'd2; cfg_data = 6'b101_111; cfg_we = 1'b1;
    cyc(); cfg_we = 1'b0;
    check("wr_rdata", int'(cfg_rdata), 47);
    run_from(3'd0);
    check("wr_s0", int'(s), 0);
    cyc();
    check("wr_s1", int'(s), 7);
    cyc();
    check("wr_state5", int'(state), 5);
    check("wr_s5", int'(s), 0);
    cyc();
    cfg_addr = 4'd2; cfg_data = 6'd0; cfg_we = 1'b1;
    cyc(); cfg_we = 1'b0;
    check("run_wr_err", int'(cfg_err), 1);
    check("run_wr_rdata", int'(cfg_rdata), 47);
    cyc();
    check("run_wr_err_pulse", int'(cfg_err), 0);

    // Reset mid-run restores the default table.
    #2 reset = 1'b0;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_state", int'(state), 0);
    check("mid_rst_rdata2", int'(cfg_rdata), 19);
    @(negedge clk); #1 reset = 1'b1;
    cyc();

    // Write and start in the same IDLE cycle: first lookup sees the new entry.
    cfg_addr = 4'd0; cfg_data = 6'b011_110; cfg_we = 1'b1;
    run_from(3'd0);
    cfg_we = 1'b0;
    check("wr_start_s", int'(s), 6);
    cyc();
    check("wr_start_state", int'(state), 3);
    stop = 1'b1; cyc(); stop = 1'b0;
    cyc();

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_seq_ctrl.md
# fsm_seq_ctrl

Programmable table-driven state-machine sequencer. Holds a writable 16-entry transition table indexed by {state, a}; each entry gives the next state and the 3-bit output. A small run controller (IDLE/RUN) starts, steps and terminates the machine on stop request, halt state or step limit. Resets to a built-in default program, the 0/3/2/4/5 counting cycle used across the design.

## Interface
Parameters:
- MAXW, 8, width of step counter and step limit

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low
- cfg_we  in  1  table write strobe
- cfg_addr  in  4  table index {state[2:0], a}
- cfg_data  in  6  entry {next[5:3], out[2:0]}
- cfg_rdata  out  6  table[cfg_addr], combinational
- cfg_err  out  1  one-cycle pulse: write rejected
- start  in  1  begin run (IDLE only)
- start_st  in  3  initial state, sampled with start
- stop  in  1  abort run
- halt_en  in  1  enable halt-state termination
- halt_st  in  3  halt state
- max_steps  in  MAXW  step limit, 0 = unlimited
- a  in  1  machine input
- s  out  3  machine output
- state  out  3  current state
- busy  out  1  high in RUN
- steps  out  MAXW  transitions taken this run, saturating
- done  out  1  one-cycle pulse on termination
- done_code  out  2  01 halt, 10 limit, 11 stop; held until next start

## Operation
- Reset values: table = default program; state=0, busy=0, steps=0, done=0, done_code=00, cfg_err=0; controller in IDLE.
- Default program (address: next/out): 0,1: 1/0; 2: 2/3; 3: 4/3; 4,5: 3/2; 6: 0/4; 7: 1/4; 8,9: 2/5; 10–15: 0/0.
- s = table[{state,a}].out when busy, else 0 (combinational).
- IDLE: cfg_we writes table[cfg_addr] at the edge. start: state<=start_st, steps<=0, done_code<=00, go RUN. cfg_we and start in the same cycle: both take effect; first RUN lookup sees the new entry.
- RUN, each edge, priority order:
  1. stop=1: state unchanged, go IDLE, done, done_code=11.
  2. Otherwise state<=next, steps<=steps+1 (saturates at all-ones). Then if halt_en and next==halt_st: IDLE, done_code=01; else if max_steps!=0 and steps+1==max_steps: IDLE, done_code=10. Halt wins over limit when both hold.
- cfg_we in RUN: table unchanged, cfg_err pulses next cycle.
- start in RUN is ignored.
- state and steps hold their final values in IDLE.
- Unused states 5–7 follow their table entries (default 0/0).
- Reset mid-run: immediate return to reset values, including the table.

## Timing
- start sampled at edge k: busy=1 and state=start_st after k; first transition at k+1.
- One transition per clock in RUN; no wait states.
- done asserted for the cycle after the terminating edge; busy drops at the same edge.
- Table write is visible on cfg_rdata and in lookups from the cycle after the write edge.
- a must be stable across the sampling edge; s follows a combinationally.

## Test plan
- Default program, start_st=0, a=0, max_steps=0: s = 0,3,2,4,0,3,2,4 per cycle; state = 0,1,2,3,0,...
- Default program, a=1: s = 0,3,5,2,4,3,5,2,4; state = 0,1,4,2,3,1,4,...
- max_steps=4, a=0: done after 4 transitions; steps=4, state=0, done_code=10, busy=0. Add halt_en=1, halt_st=0: done_code=01.
- halt_en=1, halt_st=3, a=0, start_st=0: terminates after 3 transitions; state=3, done_code=01. stop at cycle 2 instead: state=1, done_code=11.
- In IDLE, write addr 2 = 6'b101_111; run with a=0: s = 0,7,... and state goes to 5. cfg_we in RUN: cfg_err=1 for one cycle; cfg_rdata unchanged.
- Reset during RUN after a table write: busy=0, state=0; cfg_rdata at addr 2 = 6'd19.
